// File: rtl/sm83_pkg.sv
// Shared SM83 constants and the fetch-queue payload type.
package sm83_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0000;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding {byte, address} entries; flush empties it in one cycle.
module fetch_fifo
    import sm83_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [ENTRY_W-1:0]       head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    // Guard against pushing when full or popping when empty.
    always_comb begin
        do_push = push && (count != CNT_W'(DEPTH));
        do_pop  = pop && (count != '0);
        head    = mem[rd_ptr];
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[PTR_W'(i)] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rom_fetch.sv
// Instruction prefetcher: streams bytes from a synchronous ROM into a small queue,
// with credit-based issue so every inflight read already owns a queue slot.
module rom_fetch
    import sm83_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_byte,
    output logic [ADDR_W-1:0] out_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  addr_q;
    logic               inflight;
    logic [CNT_W-1:0]   count;
    logic [OCC_W-1:0]   occupancy;
    logic               issue;
    logic               push;
    logic               pop;
    fetch_entry_t       push_entry;
    fetch_entry_t       head_entry;
    logic [ENTRY_W-1:0] head_bits;

    // Issue decision, ROM address mux and queue handshakes; redirect overrides all.
    always_comb begin
        occupancy       = OCC_W'(count) + OCC_W'(inflight);
        issue           = rst_n && !redirect && (occupancy < OCC_W'(DEPTH));
        rom_en          = issue;
        rom_addr        = issue ? pc : addr_q;
        out_valid       = (count != '0);
        push            = inflight && !redirect;
        pop             = out_valid && out_ready && !redirect;
        push_entry.data = rom_data;
        push_entry.pc   = addr_q;
        head_entry      = fetch_entry_t'(head_bits);
        out_byte        = head_entry.data;
        out_pc          = head_entry.pc;
    end

    // Fetch pointer, last issued address and inflight flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            addr_q   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (redirect) begin
                pc <= redirect_pc;
            end else if (issue) begin
                pc     <= pc + ADDR_W'(1);
                addr_q <= pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect),
        .count     (count),
        .head      (head_bits)
    );

endmodule

// File: tb/tb_rom_fetch.sv
// Bench for rom_fetch: ROM model, expected-stream scoreboard, directed and random stimulus.
module tb_rom_fetch;
    import sm83_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rom_en;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_byte;
    logic [15:0] out_pc;

    rom_fetch #(
        .DEPTH    (4),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_byte    (out_byte),
        .out_pc      (out_pc)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data appears the cycle after the enable.
    logic [7:0] rom [0:65535];
    always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

    typedef struct {
        logic [15:0] pc;
        logic [7:0]  data;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] fill_pc = 16'h0000;
    int          checks = 0;
    int          failures = 0;
    int          xfer_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, req);
        end
    endtask

    // Expected decoder stream: consecutive addresses from the last restart point.
    task automatic topup();
        exp_t e;
        while (exp_q.size() < 32) begin
            e.pc   = fill_pc;
            e.data = rom[fill_pc];
            exp_q.push_back(e);
            fill_pc = fill_pc + 16'h0001;
        end
    endtask

    task automatic restart(input logic [15:0] pc);
        exp_q.delete();
        fill_pc = pc;
        topup();
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        topup();
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Monitor: every accepted byte must be the next one of the expected stream.
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !redirect) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty actual_pc=%0h", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_out_pc", 32'(out_pc), 32'(mon_e.pc));
                chk("sb_out_byte", 32'(out_byte), 32'(mon_e.data));
            end
        end
    end

    initial begin
        int x0;
        for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
        rom[0] = 8'h00; rom[1] = 8'h31; rom[2] = 8'hFE; rom[3] = 8'hFF;
        rom[4] = 8'hAF; rom[5] = 8'h21; rom[6] = 8'hFF; rom[7] = 8'h9F;
        restart(RESET_PC_DEFAULT);

        // Reset state.
        next();
        sample();
        chk("rst_rom_en", 32'(rom_en), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_byte", 32'(out_byte), 32'd0);
        chk("rst_out_pc", 32'(out_pc), 32'd0);

        // Streaming from reset with out_ready=1.
        next();
        rst_n = 1'b1;
        restart(RESET_PC_DEFAULT);
        for (int k = 0; k < 10; k++) begin
            sample();
            chk("stream_rom_en", 32'(rom_en), 32'd1);
            chk("stream_rom_addr", 32'(rom_addr), 32'(k));
            chk("stream_out_valid", 32'(out_valid), 32'(k >= 2));
            if (k >= 2) chk("stream_out_pc", 32'(out_pc), 32'(k - 2));
            next();
        end

        // Backpressure from reset: exactly DEPTH reads, then resume at addr 4.
        rst_n = 1'b0;
        out_ready = 1'b0;
        next();
        rst_n = 1'b1;
        restart(RESET_PC_DEFAULT);
        for (int k = 0; k < 8; k++) begin
            sample();
            chk("bp_rom_en", 32'(rom_en), 32'(k < 4));
            chk("bp_rom_addr", 32'(rom_addr), (k < 4) ? 32'(k) : 32'd3);
            next();
        end
        sample();
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_out_pc", 32'(out_pc), 32'd0);
        next();
        out_ready = 1'b1;
        sample();
        chk("bp_pop_rom_en", 32'(rom_en), 32'd0);
        next();
        sample();
        chk("bp_resume_rom_en", 32'(rom_en), 32'd1);
        chk("bp_resume_rom_addr", 32'(rom_addr), 32'd4);
        next();

        // Redirect while queue holds 3 bytes and one read is inflight.
        rst_n = 1'b0;
        out_ready = 1'b0;
        next();
        rst_n = 1'b1;
        restart(RESET_PC_DEFAULT);
        repeat (4) next();
        redirect = 1'b1;
        redirect_pc = 16'h0150;
        out_ready = 1'b1;
        restart(16'h0150);
        sample();
        chk("rd_n_rom_en", 32'(rom_en), 32'd0);
        next();
        redirect = 1'b0;
        sample();
        chk("rd_n1_out_valid", 32'(out_valid), 32'd0);
        chk("rd_n1_rom_en", 32'(rom_en), 32'd1);
        chk("rd_n1_rom_addr", 32'(rom_addr), 32'h0150);
        next();
        sample();
        chk("rd_n2_out_valid", 32'(out_valid), 32'd0);
        next();
        sample();
        chk("rd_n3_out_valid", 32'(out_valid), 32'd1);
        chk("rd_n3_out_pc", 32'(out_pc), 32'h0150);
        next();

        // Redirect near the top of the address space: wrap and full throughput.
        redirect = 1'b1;
        redirect_pc = 16'hFFFE;
        restart(16'hFFFE);
        next();
        redirect = 1'b0;
        x0 = xfer_cnt;
        repeat (8) next();
        chk("wrap_xfers", 32'(xfer_cnt - x0), 32'd6);

        // Redirect during an accepted transfer, then back-to-back redirects.
        redirect = 1'b1;
        redirect_pc = 16'h0100;
        restart(16'h0100);
        sample();
        chk("b2b_n_out_valid", 32'(out_valid), 32'd1);
        next();
        redirect_pc = 16'h0200;
        restart(16'h0200);
        sample();
        chk("b2b_n1_rom_en", 32'(rom_en), 32'd0);
        next();
        redirect = 1'b0;
        sample();
        chk("b2b_n2_out_valid", 32'(out_valid), 32'd0);
        chk("b2b_n2_rom_en", 32'(rom_en), 32'd1);
        chk("b2b_n2_rom_addr", 32'(rom_addr), 32'h0200);
        next();
        sample();
        chk("b2b_n3_out_valid", 32'(out_valid), 32'd0);
        next();
        sample();
        chk("b2b_n4_out_valid", 32'(out_valid), 32'd1);
        chk("b2b_n4_out_pc", 32'(out_pc), 32'h0200);
        next();
        repeat (3) next();

        // Partial-cycle reset pulse mid-stream.
        sample();
        chk("pulse_pre_out_valid", 32'(out_valid), 32'd1);
        next();
        rst_n = 1'b0;
        #2;
        chk("pulse_out_valid", 32'(out_valid), 32'd0);
        chk("pulse_out_pc", 32'(out_pc), 32'd0);
        chk("pulse_out_byte", 32'(out_byte), 32'd0);
        chk("pulse_rom_en", 32'(rom_en), 32'd0);
        chk("pulse_rom_addr", 32'(rom_addr), 32'd0);
        restart(RESET_PC_DEFAULT);
        #1;
        rst_n = 1'b1;
        sample();
        chk("pulse_c0_rom_en", 32'(rom_en), 32'd1);
        chk("pulse_c0_rom_addr", 32'(rom_addr), 32'd0);
        next();
        next();
        sample();
        chk("pulse_c2_out_valid", 32'(out_valid), 32'd1);
        chk("pulse_c2_out_pc", 32'(out_pc), 32'd0);
        next();

        // Random backpressure and redirects checked by the scoreboard.
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                redirect = 1'b1;
                redirect_pc = ($urandom_range(0, 1) != 0) ? 16'($urandom)
                                                          : 16'hFFF0 + 16'($urandom_range(0, 15));
                restart(redirect_pc);
            end else begin
                redirect = 1'b0;
            end
            next();
        end
        redirect = 1'b0;
        out_ready = 1'b1;
        repeat (10) next();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
